// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry elastic pipeline register with a valid/ready handshake on both
// sides. It is a drop-in replacement for a load-enabled stage register where
// the consumer can stall on its own. in_ready comes straight from a flop, so
// no combinational ready path runs from the downstream side to the upstream
// side. The skid entry catches the word that is already in flight when a
// downstream stall is first seen.
//
// Parameters:
//   width      data bits per entry
//   reset_val  value of out_data after reset
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous reset, active-low
//   in_valid   upstream presents in_data
//   in_data    upstream payload
//   in_ready   stage can accept this cycle (registered)
//   out_valid  out_data holds a valid entry (registered)
//   out_data   head entry (registered)
//   out_ready  downstream takes the head entry this cycle
//   flush      only present when PIPE_SKID_FLUSH_EN is defined; it empties
//              the stage and discards any word accepted on the same edge
//
// Optional feature macro: PIPE_SKID_FLUSH_EN
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int               width     = 16,
  parameter logic [width-1:0] reset_val = {width{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [width-1:0]   main_q;
  logic [width-1:0]   main_d;
  logic [width-1:0]   skid_q;
  logic [width-1:0]   skid_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic               in_ready_q;
  logic               in_ready_d;

  logic               accept_s;
  logic               deliver_s;

  // Handshakes are judged against the registered outputs the neighbours see.
  assign accept_s  = in_valid & in_ready_q;
  assign deliver_s = out_valid_q & out_ready;

  // Next-state and storage update for the two-entry queue.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        case ({accept_s, deliver_s})
          2'b10: begin
            // Downstream stalled while a word arrived: park it in skid.
            state_d = ST_FULL;
            skid_d  = in_data;
          end
          2'b01: begin
            state_d = ST_EMPTY;
          end
          2'b11: begin
            // Pass-through: the new word replaces the one just taken.
            state_d = ST_ONE;
            main_d  = in_data;
          end
          default: begin
            state_d = ST_ONE;
          end
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only a deliver can move the state.
        if (deliver_s) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

`ifdef PIPE_SKID_FLUSH_EN
    // Flush wins over any simultaneous accept or deliver; out_data holds.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end else begin
      state_d = state_d;
    end
`endif

    // Output flags are decoded from the next state so they can be flopped.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= reset_val;
      skid_q      <= {width{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Self-checking bench for pipe_skid_stage. A reference queue (occupancy plus
// FIFO contents) is updated on the falling edge from the bench's own inputs;
// words are pushed when the model accepts and popped/compared when the model
// delivers. Scenario tasks add their own targeted checks.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam int          W   = 16;
  localparam logic [15:0] RST = 16'hBEEF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = 16'h0000;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic          flush_s = 1'b0;

  int            total = 0;
  int            bad = 0;

  // reference model
  logic [W-1:0]  exp_q[$];
  int            occ = 0;
  logic [W-1:0]  main_m = RST;
  logic          acc_flag = 1'b0;
  logic          mon_en = 1'b0;

  pipe_skid_stage #(
    .width     (W),
    .reset_val (RST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_SKID_FLUSH_EN
    ,
    .flush     (flush_s)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: check outputs against the model, then advance it.
  initial begin
    logic          m_acc;
    logic          m_del;
    logic          exp_rdy;
    logic          exp_vld;
    logic [W-1:0]  exp_d;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n) begin
        exp_rdy = (occ < 2) ? 1'b1 : 1'b0;
        exp_vld = (occ > 0) ? 1'b1 : 1'b0;
        m_acc   = in_valid & exp_rdy;
        m_del   = exp_vld & out_ready;
        total++;
        if (in_ready !== exp_rdy) begin
          bad++;
          $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
        end
        total++;
        if (out_valid !== exp_vld) begin
          bad++;
          $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_vld);
        end
        if (flush_s) begin
          total++;
          if (out_data !== main_m) begin
            bad++;
            $display("FAIL sb_data_flush t=%0t got=%h exp=%h", $time, out_data, main_m);
          end
          occ = 0;
          exp_q.delete();
          acc_flag = 1'b0;
        end else begin
          if (m_del) begin
            exp_d = exp_q.pop_front();
            occ--;
          end else begin
            exp_d = main_m;
          end
          total++;
          if (out_data !== exp_d) begin
            bad++;
            $display("FAIL sb_out_data t=%0t got=%h exp=%h", $time, out_data, exp_d);
          end
          if (m_acc) begin
            exp_q.push_back(in_data);
            occ++;
          end
          if (occ > 0) main_m = exp_q[0];
          acc_flag = m_acc;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    occ = 0;
    exp_q.delete();
    main_m = RST;
  endtask

  task automatic test_reset();
    // Assert reset between clock edges with DUT state still unknown.
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_data !== 16'hBEEF) begin bad++; $display("FAIL rst_out_data got=%h exp=beef", out_data); end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      @(negedge clk);
      #1;
      total++;
      if (acc_flag !== 1'b1 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready);
      end
      if (i > 1) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'(i - 1)) begin
          bad++;
          $display("FAIL stream_latency i=%0d got=%h exp=%h", i, out_data, 16'(i - 1));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall_drain();
    logic [15:0] words[3];
    int          idx;
    words[0] = 16'h00A1;
    words[1] = 16'h00A2;
    words[2] = 16'h00A3;
    out_ready = 1'b0;
    idx = 0;
    // Offer words; producer holds in_data until accepted.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = words[idx];
      @(negedge clk);
      #1;
      if (acc_flag) idx++;
      tick();
    end
    total++;
    if (idx !== 2) begin bad++; $display("FAIL fill_accepts got=%0d exp=2", idx); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    total++;
    if (out_data !== 16'h00A1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_head got=%h exp=00a1", out_data);
    end
    // Drain: A1, A2, A3 on consecutive cycles while A3 is still offered.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== words[k]) begin
        bad++;
        $display("FAIL drain_%0d got=%h exp=%h", k, out_data, words[k]);
      end
      if (acc_flag) begin
        idx++;
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    total++;
    if (out_valid !== 1'b0 || idx !== 3) begin
      bad++;
      $display("FAIL drain_end got=%b/%0d exp=0/3", out_valid, idx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00B1;
    tick();
    in_data   = 16'h00B2;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00B2 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_one got=%b/%h/%b exp=1/00b2/1", out_valid, out_data, in_ready);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_data !== 16'h00B2) begin
      bad++;
      $display("FAIL b2b_hold got=%b/%h exp=1/00b2", in_ready, out_data);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00C1;
    tick();
    in_data   = 16'h00C2;
    tick();
    in_valid  = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL midrst got=%b/%b/%h exp=0/1/beef", out_valid, in_ready, out_data);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

`ifdef PIPE_SKID_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00D1;
    tick();
    in_data   = 16'h00D2;
    tick();
    in_data   = 16'h00D3;
    flush_s   = 1'b1;
    out_ready = 1'b1;
    tick();
    flush_s   = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h00D1) begin
      bad++;
      $display("FAIL flush got=%b/%b/%h exp=0/1/00d1", out_valid, in_ready, out_data);
    end
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_stall_drain();
    test_back_to_back();
    test_mid_reset();
`ifdef PIPE_SKID_FLUSH_EN
    test_flush();
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
